// File: rtl/lnrv_icb_arbiter_if.sv
// lnrv_icb_arbiter_if: ICB command/response bundle with N packed master slots
interface lnrv_icb_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int N  = 1
);
  logic [N-1:0]      cmd_vld;
  logic [N-1:0]      cmd_rdy;
  logic [N-1:0]      cmd_write;
  logic [N*AW-1:0]   cmd_addr;
  logic [N*DW-1:0]   cmd_wdata;
  logic [N*DW/8-1:0] cmd_wstrb;
  logic [N*3-1:0]    cmd_size;
  logic [N-1:0]      rsp_vld;
  logic [N-1:0]      rsp_rdy;
  logic [N*DW-1:0]   rsp_rdata;
  logic [N-1:0]      rsp_err;
  modport master (
    output cmd_vld, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, cmd_size, rsp_rdy,
    input  cmd_rdy, rsp_vld, rsp_rdata, rsp_err
  );
  modport slave (
    input  cmd_vld, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, cmd_size, rsp_rdy,
    output cmd_rdy, rsp_vld, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/lnrv_icb_arbiter.sv
// lnrv_icb_arbiter: round-robin N-to-1 ICB arbiter with in-order response routing
module lnrv_icb_arbiter #(
  parameter int P_ADDR_WIDTH = 32,
  parameter int P_DATA_WIDTH = 32,
  parameter int P_NUM_MASTER = 2,
  parameter int P_OTS_COUNT  = 1
) (
  input  logic clk,
  input  logic reset_n,
  lnrv_icb_arbiter_if.slave  m_icb,
  lnrv_icb_arbiter_if.master s_icb
);
  localparam int N  = P_NUM_MASTER;
  localparam int AW = P_ADDR_WIDTH;
  localparam int DW = P_DATA_WIDTH;
  localparam int SW = DW / 8;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(P_OTS_COUNT + 1);
  localparam int PW = (P_OTS_COUNT > 1) ? $clog2(P_OTS_COUNT) : 1;

  logic [IW-1:0] rr_ptr_q, rr_ptr_d, lock_idx_q, lock_idx_d, grant, head, ix;
  logic [IW:0]   sum;
  logic          lock_q, lock_d;
  logic [IW-1:0] fifo_q [P_OTS_COUNT];
  logic [IW-1:0] fifo_d [P_OTS_COUNT];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ots_full, ots_empty, cmd_hs, rsp_hs;
  logic [AW-1:0] addr_a  [N];
  logic [DW-1:0] wdata_a [N];
  logic [SW-1:0] wstrb_a [N];
  logic [2:0]    size_a  [N];

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign addr_a[i]  = m_icb.cmd_addr[i*AW +: AW];
    assign wdata_a[i] = m_icb.cmd_wdata[i*DW +: DW];
    assign wstrb_a[i] = m_icb.cmd_wstrb[i*SW +: SW];
    assign size_a[i]  = m_icb.cmd_size[i*3 +: 3];
  end

  // scan downward so the requester closest to rr_ptr is the last (winning) assignment
  always_comb begin
    sum   = '0;
    ix    = '0;
    grant = rr_ptr_q;
    for (int k = N - 1; k >= 0; k--) begin
      sum = {1'b0, rr_ptr_q} + (IW+1)'(k);
      ix  = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : IW'(sum);
      if (m_icb.cmd_vld[ix]) grant = ix;
    end
    if (lock_q) grant = lock_idx_q;
  end

  assign ots_full  = cnt_q == CW'(P_OTS_COUNT);
  assign ots_empty = cnt_q == '0;
  assign head      = fifo_q[rptr_q];

  assign s_icb.cmd_vld   = |m_icb.cmd_vld & ~ots_full;
  assign s_icb.cmd_write = m_icb.cmd_write[grant];
  assign s_icb.cmd_addr  = addr_a[grant];
  assign s_icb.cmd_wdata = wdata_a[grant];
  assign s_icb.cmd_wstrb = wstrb_a[grant];
  assign s_icb.cmd_size  = size_a[grant];
  assign cmd_hs          = s_icb.cmd_vld & s_icb.cmd_rdy;
  assign m_icb.cmd_rdy   = {N{cmd_hs}} & (N'(1) << grant);

  assign s_icb.rsp_rdy   = ~ots_empty & m_icb.rsp_rdy[head];
  assign rsp_hs          = s_icb.rsp_vld & s_icb.rsp_rdy;
  assign m_icb.rsp_vld   = {N{s_icb.rsp_vld & ~ots_empty}} & (N'(1) << head);
  assign m_icb.rsp_rdata = {N{s_icb.rsp_rdata}};
  assign m_icb.rsp_err   = {N{s_icb.rsp_err}};

  always_comb begin
    lock_d     = cmd_hs ? 1'b0 : (s_icb.cmd_vld ? 1'b1 : lock_q);
    lock_idx_d = (s_icb.cmd_vld & ~s_icb.cmd_rdy) ? grant : lock_idx_q;
    rr_ptr_d   = cmd_hs ? ((grant == IW'(N - 1)) ? '0 : grant + 1'b1) : rr_ptr_q;
    wptr_d     = cmd_hs ? ((wptr_q == PW'(P_OTS_COUNT - 1)) ? '0 : wptr_q + 1'b1) : wptr_q;
    rptr_d     = rsp_hs ? ((rptr_q == PW'(P_OTS_COUNT - 1)) ? '0 : rptr_q + 1'b1) : rptr_q;
    cnt_d      = cnt_q + CW'(cmd_hs) - CW'(rsp_hs);
    fifo_d     = fifo_q;
    if (cmd_hs) fifo_d[wptr_q] = grant;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q   <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      fifo_q     <= '{default: '0};
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      fifo_q     <= fifo_d;
    end
  end

  a_rsp_when_empty: assert property (@(posedge clk) disable iff (!reset_n) !(s_icb.rsp_vld && ots_empty));
endmodule

// File: tb/tb_lnrv_icb_arbiter.sv
// tb_lnrv_icb_arbiter: directed bench for the 2-master, 2-outstanding arbiter with a routing scoreboard
module tb_lnrv_icb_arbiter;
  logic clk = 1'b0;
  logic reset_n;
  int   tests = 0;
  int   fails = 0;
  int   exp_q[$];

  always #5 clk = ~clk;

  lnrv_icb_arbiter_if #(.AW(32), .DW(32), .N(2)) m_if();
  lnrv_icb_arbiter_if #(.AW(32), .DW(32), .N(1)) s_if();

  lnrv_icb_arbiter #(
    .P_ADDR_WIDTH(32), .P_DATA_WIDTH(32), .P_NUM_MASTER(2), .P_OTS_COUNT(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .m_icb(m_if), .s_icb(s_if)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // pop the expected owner of the current response and check it is the only one signalled
  task automatic rsp_pop(input string tag);
    int h;
    h = (exp_q.size() > 0) ? exp_q.pop_front() : 7;
    chk({tag, "_vld"}, 64'(m_if.rsp_vld), 64'(1) << h);
    chk({tag, "_srdy"}, 64'(s_if.rsp_rdy), 64'd1);
  endtask

  initial begin
    reset_n          = 1'b0;
    m_if.cmd_vld     = '0;
    m_if.cmd_write   = '0;
    m_if.cmd_addr    = '0;
    m_if.cmd_wdata   = '0;
    m_if.cmd_wstrb   = '0;
    m_if.cmd_size    = '0;
    m_if.rsp_rdy     = 2'b11;
    s_if.cmd_rdy     = 1'b1;
    s_if.rsp_vld     = 1'b0;
    s_if.rsp_rdata   = '0;
    s_if.rsp_err     = 1'b0;
    @(negedge clk); #1;
    chk("rst_mcmd_rdy", 64'(m_if.cmd_rdy), 64'd0);
    chk("rst_mrsp_vld", 64'(m_if.rsp_vld), 64'd0);
    chk("rst_scmd_vld", 64'(s_if.cmd_vld), 64'd0);
    chk("rst_srsp_rdy", 64'(s_if.rsp_rdy), 64'd0);
    reset_n = 1'b1;

    // single write from master0, forwarded in the same cycle
    @(negedge clk);
    m_if.cmd_vld = 2'b01; m_if.cmd_write = 2'b01;
    m_if.cmd_addr = {32'h0, 32'h1000}; m_if.cmd_wdata = {32'h0, 32'hDEADBEEF};
    m_if.cmd_wstrb = 8'h0f; m_if.cmd_size = {3'd0, 3'd2};
    #1;
    chk("t1_svld", 64'(s_if.cmd_vld), 64'd1);
    chk("t1_addr", 64'(s_if.cmd_addr), 64'h1000);
    chk("t1_wdata", 64'(s_if.cmd_wdata), 64'hDEADBEEF);
    chk("t1_write", 64'(s_if.cmd_write), 64'd1);
    chk("t1_wstrb", 64'(s_if.cmd_wstrb), 64'hf);
    chk("t1_size", 64'(s_if.cmd_size), 64'd2);
    chk("t1_mrdy", 64'(m_if.cmd_rdy), 64'b01);
    exp_q.push_back(0);
    @(negedge clk);
    m_if.cmd_vld = 2'b00; #1;
    chk("t1_norsp", 64'(m_if.rsp_vld), 64'd0);
    @(negedge clk);
    s_if.rsp_vld = 1'b1; s_if.rsp_rdata = 32'h5A5A1234; #1;
    rsp_pop("t1_rsp");
    chk("t1_rdata", m_if.rsp_rdata, {2{32'h5A5A1234}});
    @(negedge clk);
    s_if.rsp_vld = 1'b0;
    #2 reset_n = 1'b0;
    #2 reset_n = 1'b1;

    // both masters always requesting: strict alternation, response one cycle behind
    m_if.cmd_write = 2'b00; m_if.cmd_addr = {32'h200, 32'h100};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      m_if.cmd_vld = 2'b11; s_if.rsp_vld = (i > 0); #1;
      if (i > 0) rsp_pop("t2_rsp");
      chk("t2_grant", 64'(m_if.cmd_rdy), 64'(1) << (i % 2));
      chk("t2_addr", 64'(s_if.cmd_addr), (i % 2) ? 64'h200 : 64'h100);
      exp_q.push_back(i % 2);
    end
    @(negedge clk);
    m_if.cmd_vld = 2'b00; s_if.rsp_vld = 1'b1; #1;
    rsp_pop("t2_last");
    @(negedge clk);
    s_if.rsp_vld = 1'b0;

    // stalled master1 keeps its grant against master0
    @(negedge clk);
    s_if.cmd_rdy = 1'b0; m_if.cmd_vld = 2'b10;
    m_if.cmd_addr = {32'h300, 32'h100}; m_if.cmd_wdata = {32'hCAFE0001, 32'h0}; #1;
    chk("t3_addr", 64'(s_if.cmd_addr), 64'h300);
    chk("t3_svld", 64'(s_if.cmd_vld), 64'd1);
    chk("t3_mrdy", 64'(m_if.cmd_rdy), 64'd0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      m_if.cmd_vld = 2'b11; #1;
      chk("t3_hold_addr", 64'(s_if.cmd_addr), 64'h300);
      chk("t3_hold_wdata", 64'(s_if.cmd_wdata), 64'hCAFE0001);
      chk("t3_hold_mrdy", 64'(m_if.cmd_rdy), 64'd0);
    end
    @(negedge clk);
    s_if.cmd_rdy = 1'b1; #1;
    chk("t3_hs_mrdy", 64'(m_if.cmd_rdy), 64'b10);
    exp_q.push_back(1);
    @(negedge clk);
    m_if.cmd_vld = 2'b01; #1;
    chk("t3_next_mrdy", 64'(m_if.cmd_rdy), 64'b01);
    chk("t3_next_addr", 64'(s_if.cmd_addr), 64'h100);
    exp_q.push_back(0);
    @(negedge clk);
    m_if.cmd_vld = 2'b00; s_if.rsp_vld = 1'b1; #1;
    rsp_pop("t3_rsp1");
    @(negedge clk); #1;
    rsp_pop("t3_rsp0");
    @(negedge clk);
    s_if.rsp_vld = 1'b0;

    // fill both outstanding slots, then a pop does not free a slot in the same cycle
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      m_if.cmd_vld = 2'b01; #1;
      chk("t4_fill_mrdy", 64'(m_if.cmd_rdy), 64'b01);
      exp_q.push_back(0);
    end
    @(negedge clk);
    m_if.cmd_vld = 2'b10; #1;
    chk("t4_full_svld", 64'(s_if.cmd_vld), 64'd0);
    chk("t4_full_mrdy", 64'(m_if.cmd_rdy), 64'd0);
    @(negedge clk);
    s_if.rsp_vld = 1'b1; #1;
    rsp_pop("t4_rsp");
    chk("t4_nobypass_svld", 64'(s_if.cmd_vld), 64'd0);
    chk("t4_nobypass_mrdy", 64'(m_if.cmd_rdy), 64'd0);
    @(negedge clk);
    s_if.rsp_vld = 1'b0; #1;
    chk("t4_after_svld", 64'(s_if.cmd_vld), 64'd1);
    chk("t4_after_mrdy", 64'(m_if.cmd_rdy), 64'b10);
    exp_q.push_back(1);
    @(negedge clk);
    m_if.cmd_vld = 2'b00;

    // head master0 back-pressures; master1's ready must not release the response
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      s_if.rsp_vld = 1'b1; m_if.rsp_rdy = 2'b10; #1;
      chk("t5_hold_vld", 64'(m_if.rsp_vld), 64'(1) << exp_q[0]);
      chk("t5_hold_srdy", 64'(s_if.rsp_rdy), 64'd0);
    end
    @(negedge clk);
    m_if.rsp_rdy = 2'b11; #1;
    rsp_pop("t5_pop0");
    @(negedge clk); #1;
    rsp_pop("t5_pop1");
    @(negedge clk);
    s_if.rsp_vld = 1'b0; #1;
    chk("t5_empty_srdy", 64'(s_if.rsp_rdy), 64'd0);
    chk("t5_empty_vld", 64'(m_if.rsp_vld), 64'd0);

    // asynchronous reset with one response pending
    @(negedge clk);
    m_if.cmd_vld = 2'b01; #1;
    chk("t6_cmd_mrdy", 64'(m_if.cmd_rdy), 64'b01);
    @(negedge clk);
    m_if.cmd_vld = 2'b00; s_if.rsp_vld = 1'b1; #1;
    chk("t6_pending_vld", 64'(m_if.rsp_vld), 64'b01);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_mrsp_vld", 64'(m_if.rsp_vld), 64'd0);
    chk("t6_rst_srsp_rdy", 64'(s_if.rsp_rdy), 64'd0);
    chk("t6_rst_scmd_vld", 64'(s_if.cmd_vld), 64'd0);
    chk("t6_rst_mcmd_rdy", 64'(m_if.cmd_rdy), 64'd0);
    exp_q.delete();
    s_if.rsp_vld = 1'b0;
    @(negedge clk);
    reset_n = 1'b1; #1;
    m_if.cmd_vld = 2'b11; #1;
    chk("t6_first_grant", 64'(m_if.cmd_rdy), 64'b01);
    exp_q.push_back(0);
    @(negedge clk); #1;
    chk("t6_second_grant", 64'(m_if.cmd_rdy), 64'b10);
    exp_q.push_back(1);
    @(negedge clk);
    m_if.cmd_vld = 2'b00; s_if.rsp_vld = 1'b1; #1;
    rsp_pop("t6_rsp0");
    @(negedge clk); #1;
    rsp_pop("t6_rsp1");
    @(negedge clk);
    s_if.rsp_vld = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
